// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 register-init sequencer: ROM markers,
// FSM state encoding and ROM word field helpers.
package ov7670_pkg;

  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;
  localparam logic [15:0] END_MARKER   = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_DECODE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic [7:0] rom_reg(input logic [15:0] word);
    return word[15:8];
  endfunction

  function automatic logic [7:0] rom_val(input logic [15:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/ov7670_delay_timer.sv
// Settle-delay timer: load arms a countdown of DELAY_CYCLES cycles; expire is
// high during the last cycle of the countdown.
module ov7670_delay_timer #(
  parameter int unsigned DELAY_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(DELAY_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds DELAY_CYCLES in the first waiting cycle, so reaching 1 marks the last one.
  assign expire = (cnt_q == CW'(1));

endmodule

// File: rtl/ov7670_config_ctrl.sv
// Walks the OV7670 init ROM and pushes each {reg, val} pair to the SCCB
// write master, honouring settle-delay and end-of-table markers and retrying NACKs.
module ov7670_config_ctrl
  import ov7670_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  input  logic              sccb_ready,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              config_done,
  output logic              config_err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              armed_q;
  logic              dly_load, dly_expire, advance;

  ov7670_delay_timer #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_delay_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (dly_load),
    .expire(dly_expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    retry_d  = retry_q;
    reg_d    = reg_q;
    val_d    = val_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    dly_load = 1'b0;
    advance  = 1'b0;

    case (state_q)
      // armed_q masks a start coinciding with the first edge after reset release.
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start && armed_q) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:    state_d = ST_WAIT_ROM;
      ST_WAIT_ROM: state_d = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == END_MARKER) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (rom_data == DELAY_MARKER) begin
          dly_load = 1'b1;
          state_d  = ST_DELAY;
        end else begin
          reg_d   = rom_reg(rom_data);
          val_d   = rom_val(rom_data);
          retry_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sccb_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (sccb_done) begin
          if (!sccb_nack) begin
            advance = 1'b1;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_ERROR;
          end
        end
      end
      ST_DELAY: begin
        if (dly_expire) advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The last ROM address finishing without an end marker terminates the table.
    if (advance) begin
      if (addr_q == '1) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      retry_q <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      retry_q <= retry_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      armed_q <= 1'b1;
    end
  end

  assign rom_addr    = addr_q;
  assign sccb_req    = (state_q == ST_SEND);
  assign sccb_reg    = reg_q;
  assign sccb_val    = val_q;
  assign busy        = busy_q;
  assign config_done = done_q;
  assign config_err  = err_q;

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Scoreboard bench for ov7670_config_ctrl: a table-walking reference model
// predicts every SCCB request, its inter-request gap and the final outcome.
module tb_ov7670_config_ctrl;

  localparam int unsigned D  = 20;
  localparam int unsigned MR = 3;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          sccb_req;
  logic          sccb_ready = 1'b0;
  logic [7:0]    sccb_reg, sccb_val;
  logic          sccb_done = 1'b0;
  logic          sccb_nack = 1'b0;
  logic          busy, config_done, config_err;

  ov7670_config_ctrl #(
    .DELAY_CYCLES(D),
    .MAX_RETRY   (MR),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_req   (sccb_req),
    .sccb_ready (sccb_ready),
    .sccb_reg   (sccb_reg),
    .sccb_val   (sccb_val),
    .sccb_done  (sccb_done),
    .sccb_nack  (sccb_nack),
    .busy       (busy),
    .config_done(config_done),
    .config_err (config_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         gap;
  } exp_t;

  exp_t        exp_q[$];
  bit          nack_plan[$];
  logic [15:0] rom[256];
  int          nack_cnt[256];
  int          checks = 0;
  int          errors = 0;
  int          lat = 5;
  bit          rand_ready = 1'b0;
  int          stall = 0;
  int          exp_outcome;
  int          exp_addr;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: walk the table, one request per attempt; gap is cycles from the
  // previous done pulse to the request (FETCH/WAIT_ROM/DECODE/SEND plus delays).
  task automatic build_model();
    int  a = 0;
    int  nd = 0;
    bit  first = 1'b1;
    bit  last_nack = 1'b0;
    bit  nk;
    int  gap;
    exp_q.delete();
    nack_plan.delete();
    forever begin
      if (rom[a] == 16'hFFFF) begin
        exp_outcome = 1; exp_addr = a; return;
      end
      if (rom[a] == 16'hFFF0) begin
        nd++;
      end else begin
        for (int k = 0; ; k++) begin
          nk  = (k < nack_cnt[a]);
          gap = first ? -1 : (last_nack ? 1 : 4 + nd * (D + 3));
          exp_q.push_back('{rom[a][15:8], rom[a][7:0], gap});
          nack_plan.push_back(nk);
          first = 1'b0; last_nack = nk; nd = 0;
          if (!nk) break;
          if (k == MR) begin
            exp_outcome = 2; exp_addr = a; return;
          end
        end
      end
      if (a == 255) begin
        exp_outcome = 1; exp_addr = 255; return;
      end
      a++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    rom_data <= rom[rom_addr];
  end

  // SCCB slave: random ready, done `lat` cycles after accept, nack from the plan.
  initial begin
    bit pending = 1'b0;
    bit pn = 1'b0;
    int cnt = 0;
    forever begin
      @(negedge clk);
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          sccb_done = 1'b1; sccb_nack = pn; pending = 1'b0;
        end
      end
      if (stall > 0) begin
        sccb_ready = 1'b0; stall--;
      end else begin
        sccb_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (sccb_req && sccb_ready && !rst) begin
        pending = 1'b1; cnt = lat;
        pn = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
      end
    end
  end

  // Monitor: compares accepted requests, request gaps and hold-while-stalled.
  initial begin
    int         since = -1;
    bit         prev_req = 1'b0, prev_wait = 1'b0;
    logic [7:0] pr = '0, pv = '0;
    exp_t       e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        since = -1; prev_req = 1'b0; prev_wait = 1'b0;
        continue;
      end
      if (since >= 0) since++;
      if (prev_wait) begin
        check("req_hold", sccb_req, 1);
        check("regval_hold", {sccb_reg, sccb_val}, {pr, pv});
      end
      if (sccb_req && !prev_req) begin
        if (exp_q.size() == 0) check("req_expected", exp_q.size(), 1);
        else if (exp_q[0].gap >= 0) check("req_gap", since, exp_q[0].gap);
      end
      if (sccb_req && sccb_ready) begin
        if (exp_q.size() == 0) begin
          check("accept_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sccb_reg", sccb_reg, e.r);
          check("sccb_val", sccb_val, e.v);
        end
      end
      if (sccb_done) since = 0;
      prev_req  = sccb_req;
      prev_wait = sccb_req && !sccb_ready;
      pr = sccb_reg;
      pv = sccb_val;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'hFFFF; nack_cnt[i] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input bit mid_start);
    int k;
    build_model();
    k = $urandom_range(2, 30);
    pulse_start();
    check("start_busy", busy, 1);
    check("start_done_clr", config_done, 0);
    check("start_err_clr", config_err, 0);
    check("start_addr", rom_addr, 0);
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (!busy) break;
      start = mid_start && (n == k);
    end
    start = 1'b0;
    check("busy_end", busy, 0);
    repeat (2) @(negedge clk);
    check("config_done", config_done, exp_outcome == 1);
    check("config_err", config_err, exp_outcome == 2);
    check("final_addr", rom_addr, exp_addr);
    check("exp_left", exp_q.size(), 0);
    repeat (8) @(negedge clk);
    check("addr_stable", rom_addr, exp_addr);
    check("req_idle", sccb_req, 0);
  endtask

  task automatic rst_mid(input bit in_delay);
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1180;
    rand_ready = 1'b0; lat = 3;
    build_model();
    if (!in_delay) stall = 40;
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (in_delay ? sccb_done : sccb_req) break;
    end
    if (in_delay) repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_req", sccb_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_flags", {config_done, config_err}, 0);
    exp_q.delete(); nack_plan.delete(); stall = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_req", sccb_req, 0);
    check("post_rst_idle_addr", rom_addr, 0);
  endtask

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    #1;
    check("reset_addr", rom_addr, 0);
    check("reset_req", sccb_req, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {config_done, config_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain table, then a settle marker, then a ready stall.
    rom[0] = 16'h1280; rom[1] = 16'h1180;
    run(1'b0);
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1180;
    run(1'b0);
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1180;
    stall = 14;
    run(1'b0);

    // NACK then ACK, then permanent NACK.
    nack_cnt[0] = 2;
    run(1'b0);
    nack_cnt[0] = 9;
    run(1'b0);

    rst_mid(1'b0);
    rst_mid(1'b1);
    repeat (2) @(negedge clk);

    for (int it = 0; it < 8; it++) begin
      int n;
      clear_rom();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) rom[i] = 16'hFFF0;
        else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        if ($urandom_range(0, 9) < 7) nack_cnt[i] = 0;
        else nack_cnt[i] = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(1, 3);
      end
      lat = $urandom_range(1, 6);
      rand_ready = 1'b1;
      run(1'b1);
    end

    // Full table with no end marker terminates at the last address.
    for (int i = 0; i < 256; i++) begin
      rom[i] = {8'(i), 8'($urandom_range(0, 255))};
      nack_cnt[i] = 0;
    end
    lat = 1; rand_ready = 1'b0;
    run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_config_ctrl.md
Name: ov7670_config_ctrl

Overview:
Sequencer that walks the OV7670 register-init ROM from address 0 and pushes each {register, value} pair to the SCCB write master. It interprets two in-band markers: 16'hFFF0 means insert a settle delay, 16'hFFFF means end of table. It retries NACKed writes and reports busy, done and error to the camera top level.

Parameters:
DELAY_CYCLES, 250000, clk cycles waited on a 16'hFFF0 marker (10 ms at 25 MHz); minimum 1.
MAX_RETRY, 3, re-attempts per entry after a NACK before flagging an error.
ADDR_W, 8, ROM address width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins configuration from address 0
rom_addr  out  ADDR_W  ROM address; ROM output is registered and valid one clk after the address
rom_data  in  16  ROM output {reg[15:8], val[7:0]}
sccb_req  out  1  write request (valid)
sccb_ready  in  1  SCCB master accepts the request when high together with sccb_req
sccb_reg  out  8  register address for the write
sccb_val  out  8  data for the write
sccb_done  in  1  one-cycle pulse when the write transaction completes
sccb_nack  in  1  qualified by sccb_done; high means the slave NACKed
busy  out  1  high from start acceptance until DONE or ERROR
config_done  out  1  level; high after the end marker is processed, cleared by the next start
config_err  out  1  level; high after retry exhaustion, cleared by the next start

Behaviour:
- Reset values: all outputs 0, state IDLE, address 0, retry count 0, delay count 0.
- States: IDLE, FETCH, WAIT_ROM, DECODE, SEND, WAIT_DONE, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR: on start, clear config_done, config_err and rom_addr, set busy, go to FETCH. start in any other state is ignored.
- FETCH: rom_addr holds the current address; go to WAIT_ROM. WAIT_ROM lasts 1 cycle to cover ROM latency.
- DECODE: sample rom_data.
  - 16'hFFFF: go to DONE. Set config_done, clear busy.
  - 16'hFFF0: load the delay counter, go to DELAY.
  - Any other value: latch sccb_reg/sccb_val, clear the retry count, go to SEND.
- SEND: sccb_req=1; sccb_reg and sccb_val stay stable. When sccb_req and sccb_ready are both high, drop sccb_req on the next edge and go to WAIT_DONE. sccb_req never drops without a transfer.
- WAIT_DONE: wait for sccb_done; no timeout.
  - sccb_done with nack=0: address+1, go to FETCH.
  - sccb_done with nack=1 and retry<MAX_RETRY: retry+1, go to SEND with the same data.
  - sccb_done with nack=1 and retry==MAX_RETRY: go to ERROR. Set config_err, clear busy.
- DELAY: count down DELAY_CYCLES cycles. On expiry, address+1, go to FETCH. The marker occupies exactly DELAY_CYCLES cycles in DELAY.
- Address wrap: if address 2^ADDR_W-1 completes without an end marker, treat it as end and go to DONE; no wrap to 0.
- Entry cost without delay: FETCH, WAIT_ROM, DECODE, then SEND (≥1 cycle), then WAIT_DONE.
- Reset asserted at any time (mid-SEND, mid-DELAY): immediate return to reset values; sccb_req drops asynchronously.
- A start pulse in the same cycle as reset release is ignored.
- Delay counter width: clog2(DELAY_CYCLES+1).

Decomposition:
- Package ov7670_pkg: DELAY_MARKER=16'hFFF0, END_MARKER=16'hFFFF, state enum, ROM word field slices.
- One sub-module, ov7670_delay_timer: load/count/expire pulse, parameterised by DELAY_CYCLES.
- The FSM, address and retry counters stay in the top.

Test Plan:
1. Mock ROM {12_80, 11_80, FFFF}, sccb_ready=1, done 5 cycles after accept, nack=0 -> exactly 2 writes (12/80, 11/80) in order; config_done=1 and busy=0 after the third fetch.
2. Mock ROM {12_80, FFF0, 11_80, FFFF}, DELAY_CYCLES=20 -> gap between the first done and the second sccb_req is 20 delay cycles plus FETCH/WAIT_ROM/DECODE/SEND overhead; no request during DELAY.
3. Hold sccb_ready=0 for 10 cycles during SEND -> sccb_req stays 1 with stable reg/val; transfer occurs on the first ready cycle.
4. First write NACKed twice then ACKed, MAX_RETRY=3 -> 3 identical requests, config_err=0, sequence completes. Always NACK -> 4 requests, then config_err=1, busy=0, no further rom_addr change.
5. start pulsed mid-sequence -> ignored, address unaffected. start after DONE -> config_done clears, rom_addr restarts at 0.
6. rst asserted while in SEND and while in DELAY -> sccb_req=0 and all outputs 0 immediately; the FSM stays in IDLE until the next start.
